// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state types, parity modes and oversampling constants for the UART core.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  SAMPLE_A   = 4'd7;
  localparam logic [3:0]  SAMPLE_B   = 4'd8;
  localparam logic [3:0]  SAMPLE_C   = 4'd9;
  localparam logic [3:0]  BIT_END    = 4'd15;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a 1-clk tick at 16x the baud rate.
module uart_baud_tick import uart_pkg::*; #(
  parameter int unsigned SYS_CLK_FREQ = 100000000,
  parameter int unsigned BAUD_RATE    = 9600
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned DIV  = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  if (DIV < 1) begin : g_div_check
    $error("uart_baud_tick: SYS_CLK_FREQ too low for BAUD_RATE*16");
  end

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  // Divider next count: wrap on tick
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Divider register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART, 16x oversampled RX with 3-sample vote.
// Define UART_LOOPBACK_EN to add a loopback input routing internal tx into the RX path.
module uart_core_param import uart_pkg::*; #(
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned SYS_CLK_FREQ = 100000000,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 rx_busy,
  output logic                 tx_busy
);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_check
    $error("uart_core_param: DATA_BITS must be 5..8");
  end
  if (PARITY > PAR_EVEN) begin : g_par_check
    $error("uart_core_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("uart_core_param: STOP_BITS must be 1 or 2");
  end

  localparam logic [2:0] LastBit  = 3'(DATA_BITS - 1);
  localparam logic       LastStop = 1'(STOP_BITS - 1);
  localparam logic       ParOdd   = (PARITY == PAR_ODD);
  localparam bit         HasPar   = (PARITY != PAR_NONE);

  logic tick;

  uart_baud_tick #(
    .SYS_CLK_FREQ(SYS_CLK_FREQ),
    .BAUD_RATE   (BAUD_RATE)
  ) u_baud_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // ---------------- RX ----------------
  rx_state_e            rx_state_q, rx_state_d;
  logic [1:0]           sync_q, sync_d;
  logic [3:0]           rx_tcnt_q, rx_tcnt_d;
  logic [2:0]           rx_bcnt_q, rx_bcnt_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [1:0]           rx_samp_q, rx_samp_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 rx_src, rx_line, vote, rx_mid, rx_end, rx_done, par_bad;

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx : rx;
`else
  assign rx_src = rx;
`endif

  assign rx_line = sync_q[1];
  // Third vote sample is the live line at SAMPLE_C
  assign vote    = majority3(rx_samp_q[0], rx_samp_q[1], rx_line);
  assign rx_mid  = tick && (rx_tcnt_q == SAMPLE_C);
  assign rx_end  = tick && (rx_tcnt_q == BIT_END);
  assign par_bad = HasPar && (rx_par_q != ((^rx_shift_q) ^ ParOdd));

  // RX synchroniser shift, bit sampling and frame FSM
  always_comb begin
    sync_d     = {sync_q[0], rx_src};
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_shift_d = rx_shift_q;
    rx_samp_d  = rx_samp_q;
    rx_par_d   = rx_par_q;
    rx_done    = 1'b0;
    if (tick) begin
      rx_tcnt_d = rx_tcnt_q + 4'd1;
      if (rx_tcnt_q == SAMPLE_A) rx_samp_d[0] = rx_line;
      if (rx_tcnt_q == SAMPLE_B) rx_samp_d[1] = rx_line;
    end
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_tcnt_d = '0;
        if (tick && !rx_line) rx_state_d = RX_START;
      end
      RX_START: begin
        // Decide on the start bit at mid-bit so a glitch frees the receiver quickly
        if (rx_mid && vote) begin
          rx_state_d = RX_IDLE;
        end else if (rx_end) begin
          rx_state_d = RX_DATA;
          rx_bcnt_d  = '0;
        end
      end
      RX_DATA: begin
        if (rx_mid) rx_shift_d = {vote, rx_shift_q[DATA_BITS-1:1]};
        if (rx_end) begin
          if (rx_bcnt_q == LastBit) begin
            if (HasPar) rx_state_d = RX_PARITY;
            else        rx_state_d = RX_STOP;
          end else begin
            rx_bcnt_d = rx_bcnt_q + 3'd1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_mid) rx_par_d = vote;
        if (rx_end) rx_state_d = RX_STOP;
      end
      RX_STOP: begin
        if (rx_mid) begin
          rx_done = 1'b1;
          if (vote) rx_state_d = RX_IDLE;
          else      rx_state_d = RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (tick && rx_line) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX output holding register with valid/ready handshake and overrun detection
  always_comb begin
    rx_valid_d    = rx_valid_q;
    rx_data_d     = rx_data_q;
    frame_err_d   = frame_err_q;
    parity_err_d  = parity_err_q;
    overrun_err_d = overrun_err_q;
    if (rx_done) begin
      rx_valid_d    = 1'b1;
      rx_data_d     = rx_shift_q;
      frame_err_d   = !vote;
      parity_err_d  = par_bad;
      overrun_err_d = rx_valid_q && !rx_ready;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // RX state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= 2'b11;
      rx_state_q    <= RX_IDLE;
      rx_tcnt_q     <= '0;
      rx_bcnt_q     <= '0;
      rx_shift_q    <= '0;
      rx_samp_q     <= 2'b11;
      rx_par_q      <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      rx_state_q    <= rx_state_d;
      rx_tcnt_q     <= rx_tcnt_d;
      rx_bcnt_q     <= rx_bcnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_samp_q     <= rx_samp_d;
      rx_par_q      <= rx_par_d;
      rx_valid_q    <= rx_valid_d;
      rx_data_q     <= rx_data_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;
  assign rx_busy     = (rx_state_q != RX_IDLE);

  // ---------------- TX ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [3:0]           tx_tcnt_q, tx_tcnt_d;
  logic [2:0]           tx_bcnt_q, tx_bcnt_d;
  logic                 tx_scnt_q, tx_scnt_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_end;

  assign tx_end = tick && (tx_tcnt_q == BIT_END);

  // TX frame sequencer; tick counter restarts on accept so each bit is exactly 16 ticks
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_scnt_d  = tx_scnt_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    if (tick) tx_tcnt_d = tx_tcnt_q + 4'd1;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_d      = 1'b1;
        tx_tcnt_d = '0;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ ParOdd;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_end) begin
          tx_state_d = TX_DATA;
          tx_bcnt_d  = '0;
          tx_d       = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_end) begin
          if (tx_bcnt_q == LastBit) begin
            if (HasPar) begin
              tx_state_d = TX_PARITY;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = TX_STOP;
              tx_scnt_d  = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            tx_bcnt_d  = tx_bcnt_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end
      end
      TX_PARITY: begin
        if (tx_end) begin
          tx_state_d = TX_STOP;
          tx_scnt_d  = 1'b0;
          tx_d       = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_end) begin
          if (tx_scnt_q == LastStop) tx_state_d = TX_IDLE;
          else                       tx_scnt_d  = 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // TX state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_scnt_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_scnt_q  <= tx_scnt_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (tx_state_q == TX_IDLE);
  assign tx_busy  = (tx_state_q != TX_IDLE);

endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: scoreboard bench; DIV=1 so one bit is 16 clks.
// u_dut is 8N1, u_dut_e is 8E1.
module tb_uart_core_param;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_n, rx_e;
  logic       tx_n, tx_e;
  logic       tx_valid_n, tx_valid_e;
  logic       tx_ready_n, tx_ready_e;
  logic [7:0] tx_data_n, tx_data_e;
  logic       rx_valid_n, rx_valid_e;
  logic       rx_ready_n, rx_ready_e;
  logic [7:0] rx_data_n, rx_data_e;
  logic       fe_n, fe_e, pe_n, pe_e, ov_n, ov_e;
  logic       rxb_n, rxb_e, txb_n, txb_e;
`ifdef UART_LOOPBACK_EN
  logic       lb;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  logic txb_q[$];

  always #5 clk = ~clk;

  uart_core_param #(
    .BAUD_RATE   (100000),
    .SYS_CLK_FREQ(1600000),
    .DATA_BITS   (8),
    .PARITY      (0),
    .STOP_BITS   (1)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef UART_LOOPBACK_EN
    .loopback   (lb),
`endif
    .rx         (rx_n),
    .tx         (tx_n),
    .tx_valid   (tx_valid_n),
    .tx_ready   (tx_ready_n),
    .tx_data    (tx_data_n),
    .rx_valid   (rx_valid_n),
    .rx_ready   (rx_ready_n),
    .rx_data    (rx_data_n),
    .frame_err  (fe_n),
    .parity_err (pe_n),
    .overrun_err(ov_n),
    .rx_busy    (rxb_n),
    .tx_busy    (txb_n)
  );

  uart_core_param #(
    .BAUD_RATE   (100000),
    .SYS_CLK_FREQ(1600000),
    .DATA_BITS   (8),
    .PARITY      (2),
    .STOP_BITS   (1)
  ) u_dut_e (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef UART_LOOPBACK_EN
    .loopback   (1'b0),
`endif
    .rx         (rx_e),
    .tx         (tx_e),
    .tx_valid   (tx_valid_e),
    .tx_ready   (tx_ready_e),
    .tx_data    (tx_data_e),
    .rx_valid   (rx_valid_e),
    .rx_ready   (rx_ready_e),
    .rx_data    (rx_data_e),
    .frame_err  (fe_e),
    .parity_err (pe_e),
    .overrun_err(ov_e),
    .rx_busy    (rxb_e),
    .tx_busy    (txb_e)
  );

  // Single-entry holding register model: an unread word is replaced and flagged as overrun.
  task automatic sb_push(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = pe;
    e.ov = (sb_q.size() > 0);
    if (sb_q.size() > 0) sb_q.delete();
    sb_q.push_back(e);
  endtask

  // Drive one serial bit for 16 clks; called at posedge+1.
  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rx_e = v;
    else     rx_n = v;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                            input logic par, input logic stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (use_par) drive_bit(sel, par);
    drive_bit(sel, stop);
  endtask

  // Transmit d on u_dut and check the line bit by bit plus the tx_ready-low length.
  task automatic run_tx_frame(input logic [7:0] d);
    int   c;
    logic exp_b;
    txb_q.delete();
    txb_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) txb_q.push_back(d[i]);
    txb_q.push_back(1'b1);
    @(posedge clk); #1;
    tx_valid_n = 1'b1;
    tx_data_n  = d;
    @(posedge clk); #1;
    tx_valid_n = 1'b0;
    tx_data_n  = ~d;
    c = 0;
    @(negedge clk);
    while (tx_ready_n !== 1'b1 && c < 400) begin
      if (c % 16 == 0 || c % 16 == 8 || c % 16 == 15) begin
        exp_b = (txb_q.size() > 0) ? txb_q[0] : 1'b1;
        total++;
        if (tx_n !== exp_b) begin
          bad++;
          $display("FAIL tx_bit data=%h clk=%0d got=%b exp=%b", d, c, tx_n, exp_b);
        end
      end
      if (c % 16 == 15 && txb_q.size() > 0) void'(txb_q.pop_front());
      c++;
      @(negedge clk);
    end
    total++;
    if (c != 160) begin
      bad++;
      $display("FAIL tx_ready_low data=%h got=%0d exp=160", d, c);
    end
    total++;
    if (txb_q.size() != 0) begin
      bad++;
      $display("FAIL tx_bits_left data=%h got=%0d exp=0", d, txb_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({tx_n, tx_ready_n, rx_valid_n, fe_n, pe_n, ov_n, rxb_n, txb_n} !== 8'b1100_0000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=11000000",
               {tx_n, tx_ready_n, rx_valid_n, fe_n, pe_n, ov_n, rxb_n, txb_n});
    end
    total++;
    if (rx_data_n !== 8'h00 || rx_data_e !== 8'h00) begin
      bad++;
      $display("FAIL reset_rx_data got=%h/%h exp=00/00", rx_data_n, rx_data_e);
    end
    total++;
    if ({tx_e, tx_ready_e, rx_valid_e, rxb_e, txb_e} !== 5'b11000) begin
      bad++;
      $display("FAIL reset_flags_e got=%b exp=11000", {tx_e, tx_ready_e, rx_valid_e, rxb_e, txb_e});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_tx_8n1();
    run_tx_frame(8'hA5);
  endtask

  task automatic test_rx_parity();
    exp_t e;
    int   n;
    for (int i = 0; i < 2; i++) begin
      logic p;
      p = i[0];
      send_frame(1'b1, 8'h3C, 1'b1, p, 1'b1);
      sb_push(8'h3C, 1'b0, p ^ (^8'h3C));
      n = 0;
      while (rx_valid_e !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      total++;
      if (rx_valid_e !== 1'b1) begin
        bad++;
        $display("FAIL par_rx_valid p=%0b got=%b exp=1", p, rx_valid_e);
      end
      e = sb_q.pop_front();
      total++;
      if (rx_data_e !== e.d) begin
        bad++;
        $display("FAIL par_rx_data p=%0b got=%h exp=%h", p, rx_data_e, e.d);
      end
      total++;
      if ({fe_e, pe_e, ov_e} !== {e.fe, e.pe, e.ov}) begin
        bad++;
        $display("FAIL par_flags p=%0b got=%b exp=%b", p, {fe_e, pe_e, ov_e}, {e.fe, e.pe, e.ov});
      end
      @(posedge clk); #1;
      rx_ready_e = 1'b1;
      @(posedge clk); #1;
      rx_ready_e = 1'b0;
      total++;
      if (rx_valid_e !== 1'b0) begin
        bad++;
        $display("FAIL par_rx_read p=%0b got=%b exp=0", p, rx_valid_e);
      end
    end
  endtask

  task automatic test_glitch();
    int n;
    rx_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_n = 1'b1;
    total++;
    if (rxb_n !== 1'b1) begin
      bad++;
      $display("FAIL glitch_busy_seen got=%b exp=1", rxb_n);
    end
    n = 0;
    while (rxb_n !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    total++;
    if (rxb_n !== 1'b0) begin
      bad++;
      $display("FAIL glitch_busy_clear got=%b exp=0 after=%0d", rxb_n, n);
    end
    repeat (30) @(posedge clk);
    #1;
    total++;
    if ({rx_valid_n, fe_n, pe_n, ov_n} !== 4'b0000) begin
      bad++;
      $display("FAIL glitch_no_word got=%b exp=0000", {rx_valid_n, fe_n, pe_n, ov_n});
    end
  endtask

  task automatic test_frame_err();
    exp_t e;
    int   n;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    sb_push(8'h5A, 1'b1, 1'b0);
    repeat (24) @(posedge clk);
    #1;
    n = 0;
    while (rx_valid_n !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    e = sb_q.pop_front();
    total++;
    if ({rx_valid_n, rx_data_n} !== {1'b1, e.d}) begin
      bad++;
      $display("FAIL ferr_word got=%b/%h exp=1/%h", rx_valid_n, rx_data_n, e.d);
    end
    total++;
    if ({fe_n, pe_n, ov_n} !== {e.fe, e.pe, e.ov}) begin
      bad++;
      $display("FAIL ferr_flags got=%b exp=%b", {fe_n, pe_n, ov_n}, {e.fe, e.pe, e.ov});
    end
    total++;
    if (rxb_n !== 1'b1) begin
      bad++;
      $display("FAIL ferr_busy_in_break got=%b exp=1", rxb_n);
    end
    @(posedge clk); #1;
    rx_ready_n = 1'b1;
    @(posedge clk); #1;
    rx_ready_n = 1'b0;
    total++;
    if (rx_valid_n !== 1'b0) begin
      bad++;
      $display("FAIL ferr_read got=%b exp=0", rx_valid_n);
    end
    rx_n = 1'b1;
    n = 0;
    while (rxb_n !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (rxb_n !== 1'b0) begin
      bad++;
      $display("FAIL ferr_break_exit got=%b exp=0", rxb_n);
    end
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (rx_valid_n !== 1'b0) begin
      bad++;
      $display("FAIL ferr_second_word got=%b exp=0", rx_valid_n);
    end
  endtask

  task automatic test_overrun();
    exp_t e;
    int   n;
    rx_ready_n = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    sb_push(8'h11, 1'b0, 1'b0);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    sb_push(8'h22, 1'b0, 1'b0);
    n = 0;
    while (rx_valid_n !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    e = sb_q.pop_front();
    total++;
    if ({rx_valid_n, rx_data_n} !== {1'b1, e.d}) begin
      bad++;
      $display("FAIL ovr_word got=%b/%h exp=1/%h", rx_valid_n, rx_data_n, e.d);
    end
    total++;
    if ({fe_n, pe_n, ov_n} !== {e.fe, e.pe, e.ov}) begin
      bad++;
      $display("FAIL ovr_flags got=%b exp=%b", {fe_n, pe_n, ov_n}, {e.fe, e.pe, e.ov});
    end
    @(posedge clk); #1;
    rx_ready_n = 1'b1;
    @(posedge clk); #1;
    rx_ready_n = 1'b0;
    total++;
    if (rx_valid_n !== 1'b0) begin
      bad++;
      $display("FAIL ovr_read got=%b exp=0", rx_valid_n);
    end
  endtask

  task automatic test_reset_mid_tx();
    // 0xC3 has data bit 3 = 0, so the line is low when reset hits
    @(posedge clk); #1;
    tx_valid_n = 1'b1;
    tx_data_n  = 8'hC3;
    @(posedge clk); #1;
    tx_valid_n = 1'b0;
    repeat (70) @(posedge clk);
    #3;
    total++;
    if ({tx_n, txb_n} !== 2'b01) begin
      bad++;
      $display("FAIL rst_mid_pre got=%b exp=01", {tx_n, txb_n});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({tx_n, tx_ready_n, txb_n} !== 3'b110) begin
      bad++;
      $display("FAIL rst_mid_async got=%b exp=110", {tx_n, tx_ready_n, txb_n});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef UART_LOOPBACK_EN
    lb = 1'b1;
    sb_push(8'h00, 1'b0, 1'b0);
`endif
    run_tx_frame(8'h00);
`ifdef UART_LOOPBACK_EN
    begin
      exp_t e;
      int   n;
      n = 0;
      while (rx_valid_n !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      e = sb_q.pop_front();
      total++;
      if ({rx_valid_n, rx_data_n, fe_n, pe_n, ov_n} !== {1'b1, e.d, e.fe, e.pe, e.ov}) begin
        bad++;
        $display("FAIL loopback_word got=%b/%h/%b exp=1/%h/%b", rx_valid_n, rx_data_n,
                 {fe_n, pe_n, ov_n}, e.d, {e.fe, e.pe, e.ov});
      end
      lb = 1'b0;
    end
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    rx_n       = 1'b1;
    rx_e       = 1'b1;
    tx_valid_n = 1'b0;
    tx_valid_e = 1'b0;
    tx_data_n  = 8'h00;
    tx_data_e  = 8'h00;
    rx_ready_n = 1'b0;
    rx_ready_e = 1'b0;
`ifdef UART_LOOPBACK_EN
    lb = 1'b0;
`endif
    test_reset();
    test_tx_8n1();
    test_rx_parity();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Parametrised successor to the team's fixed 8N1 UART: full-duplex serial transceiver with configurable data width, parity mode, stop-bit count and 16x oversampling.
- RX takes a 3-sample majority vote per bit and reports framing, parity and overrun errors.
- TX and RX use valid/ready handshakes instead of level-held strobes.
- Sits between the host-facing serial pins and the miner's command/result byte streams.

Parameters:
- BAUD_RATE, 9600: line bit rate.
- SYS_CLK_FREQ, 100000000: clk frequency in Hz.
- DATA_BITS, 8: payload bits per frame, legal range 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2; TX sends this many stop bits, RX checks only the first.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  serial input, asynchronous to clk
- tx  out  1  serial output, idles high
- tx_valid  in  1  tx_data is offered for transmission
- tx_ready  out  1  transmitter can accept a word
- tx_data  in  DATA_BITS  word to transmit, sent LSB first
- rx_valid  out  1  rx_data and the error flags hold an unread word
- rx_ready  in  1  consumer accepts the word
- rx_data  out  DATA_BITS  received word
- frame_err  out  1  stop bit sampled low for the word in rx_data
- parity_err  out  1  parity mismatch for the word in rx_data; always 0 when PARITY = 0
- overrun_err  out  1  a new word overwrote an unread word
- rx_busy  out  1  RX state is not RX_IDLE
- tx_busy  out  1  TX state is not TX_IDLE

Behaviour:
- Reset is asynchronous and active-low, and overrides everything including a frame in progress. Reset values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, all error flags 0, both busy flags 0, both FSMs idle, both synchroniser flops 1.
- Tick: free-running divider produces a 1-clk tick every DIV = SYS_CLK_FREQ/(BAUD_RATE*16) clocks, rounded down. DIV must be at least 1; otherwise fail elaboration.
- RX input path: rx passes through a 2-flop synchroniser; all RX logic uses the synchronised value.
- RX states: RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK.
- RX bit timing: a 4-bit tick counter per bit samples the line at ticks 7, 8 and 9 and takes the majority. The bit ends at tick 15.
- RX_IDLE -> RX_START when the synchronised line is low on a tick.
- RX_START: majority 1 = glitch; return to RX_IDLE with no flags and no rx_valid. Majority 0 -> RX_DATA.
- RX_DATA: shift DATA_BITS bits LSB first. Then go to RX_PARITY if PARITY != 0, else RX_STOP.
- RX_PARITY: compute expected parity as the XOR of the data bits, inverted for odd parity; compare with the received bit.
- RX_STOP at tick 9:
  - Load rx_data and the flags, and set rx_valid on the next clk edge.
  - Majority 0 -> frame_err=1, then RX_BREAK. RX_BREAK waits until the line is high on a tick, then goes to RX_IDLE.
  - Majority 1 -> RX_IDLE immediately, so the next start bit can be caught at half-bit granularity.
- RX output handshake: rx_valid stays high until the cycle where rx_valid && rx_ready, then clears on the next edge. Data and flags are held while rx_valid is high.
- RX overrun: if a new word completes while rx_valid=1 and rx_ready=0, the new word and flags overwrite the old, overrun_err=1, and rx_valid stays 1. If rx_ready=1 in that same cycle, the new word loads with overrun_err=0.
- TX states: TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP. tx_ready = (state == TX_IDLE).
- TX accept: on tx_valid && tx_ready, latch tx_data. tx goes low on the next edge and the TX tick counter restarts, so every bit lasts exactly 16 ticks.
- TX sequence: START -> DATA (DATA_BITS bits, LSB first) -> PARITY (only if PARITY != 0) -> STOP (STOP_BITS x 16 ticks, tx=1) -> TX_IDLE. tx_ready rises the clk after the last stop tick.
- tx_data changing mid-frame has no effect.
- TX and RX are fully independent; simultaneous activity is legal.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the RX synchroniser input is the internal tx and the external rx is ignored; the tx pin is still driven normally.
- Undefined: no loopback port and no mux; the RX synchroniser is fed only from rx.

Decomposition:
- Package uart_pkg holds:
  - RX and TX state typedefs.
  - Parity-mode constants PAR_NONE, PAR_ODD, PAR_EVEN.
  - OVERSAMPLE=16 and sample-point constants SAMPLE_A=7, SAMPLE_B=8, SAMPLE_C=9, BIT_END=15.
- Sub-module uart_baud_tick: the divider and tick generator, parameters SYS_CLK_FREQ and BAUD_RATE, ports clk, rst_n, tick.

Test Plan (SYS_CLK_FREQ=1600000, BAUD_RATE=100000, so DIV=1 and one bit = 16 clks):
- 8N1 TX of 0xA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 clks; tx_ready low for exactly 160 clks.
- 8E1 RX of 0x3C with correct parity bit 0 -> rx_valid, rx_data=0x3C, parity_err=0. Repeat with parity bit 1 -> parity_err=1.
- Stop bit driven 0, line held low 40 clks -> rx_valid, frame_err=1, rx_busy high until the line returns high; no second word.
- 4-clk low glitch on rx -> no rx_valid, no error flags, rx_busy returns 0 within 10 clks.
- Two back-to-back frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x22, overrun_err=1. One rx_ready pulse -> rx_valid=0.
- rst_n low during TX data bit 3 -> tx=1 and tx_ready=1 asynchronously. After release, a new tx_valid of 0x00 is sent correctly. With UART_LOOPBACK_EN, loopback=1 returns 0x00 on rx_data.
